serial_rx_fifo: RTL and testbench

Parametrised serial receive front-end. It combines asynchronous serial reception, optional parity checking, a configurable-depth receive FIFO and CTS flow control with hysteresis. It sits between the `rx` pin and the UTF-8 decoder. It replaces the fixed 8N1 receiver and the single-entry buffering in front of the decoder. Its handshake allows downstream back-pressure to reach the host through `cts`.

---
 rtl/serial_rx_fifo_if.sv | 27 ++
 rtl/serial_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_serial_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_fifo_if.sv
// Receive-side stream between serial_rx_fifo and its consumer:
// first-word-fall-through head, occupancy and the downstream ready.
interface serial_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) ();
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                 receiver_ready;
    logic                 out_data_available;
    logic [DATA_BITS-1:0] out_data;
    logic [LEVEL_W-1:0]   level;

    modport master (
        input  receiver_ready,
        output out_data_available,
        output out_data,
        output level
    );

    modport slave (
        output receiver_ready,
        input  out_data_available,
        input  out_data,
        input  level
    );
endinterface

// File: rtl/serial_rx_fifo.sv
// Asynchronous serial receiver with optional parity, a receive FIFO and
// CTS flow control with hysteresis, feeding a first-word-fall-through head.
module serial_rx_fifo #(
    parameter int CLK_FREQUENCY_HZ = 108_000_000,
    parameter int SERIAL_BPS       = 1_000_000,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int FIFO_DEPTH       = 16,
    parameter int CTS_HIGH_WATER   = 12,
    parameter int CTS_LOW_WATER    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic cts,
    input  logic clear_errors,
    output logic framing_error,
    output logic parity_error,
    output logic overrun,
    serial_rx_fifo_if.master out_if
);
    localparam int BIT_TICKS  = (CLK_FREQUENCY_HZ + SERIAL_BPS / 2) / SERIAL_BPS;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS + 1);
    localparam int BIDX_W     = $clog2(DATA_BITS);
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W    = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY_BIT, STOP, BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]     tick_cnt;
    logic [BIDX_W-1:0]    bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bad;
    logic                 tick_done;
    logic                 push_req;

    // Sync flops reset low so a line already low at reset release never looks like a fresh start edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign tick_done = (tick_cnt == CNT_W'(1));
    assign push_req  = (state == STOP) && tick_done && rx_sync && !parity_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            parity_bad    <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            if (tick_cnt != '0 && !tick_done) begin
                tick_cnt <= tick_cnt - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        tick_cnt   <= CNT_W'(HALF_TICKS);
                        bit_idx    <= '0;
                        parity_bad <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick_done) begin
                        if (rx_sync) begin
                            state <= IDLE;
                        end else begin
                            tick_cnt <= CNT_W'(BIT_TICKS);
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick_done) begin
                        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        tick_cnt  <= CNT_W'(BIT_TICKS);
                        if (bit_idx == BIDX_W'(DATA_BITS - 1)) begin
                            state <= (PARITY != 0) ? PARITY_BIT : STOP;
                        end else begin
                            bit_idx <= bit_idx + BIDX_W'(1);
                        end
                    end
                end
                PARITY_BIT: begin
                    if (tick_done) begin
                        // Odd mode wants a total XOR of 1, even mode wants 0.
                        parity_bad <= (^shift_reg) ^ rx_sync ^ (PARITY == 1);
                        tick_cnt   <= CNT_W'(BIT_TICKS);
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (tick_done) begin
                        if (!rx_sync) begin
                            framing_error <= 1'b1;
                            state         <= BREAK;
                        end else begin
                            parity_error <= parity_bad;
                            state        <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [LEVEL_W-1:0]   wr_ptr, rd_ptr, level_q;
    logic [LEVEL_W-1:0]   wr_next, rd_next, level_next;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 full, pop, push_accept;

    assign level_q     = wr_ptr - rd_ptr;
    assign full        = (level_q == LEVEL_W'(FIFO_DEPTH));
    assign pop         = (level_q != '0) && out_if.receiver_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_accept = push_req && (!full || pop);
    assign wr_next     = wr_ptr + LEVEL_W'(push_accept);
    assign rd_next     = rd_ptr + LEVEL_W'(pop);
    assign level_next  = wr_next - rd_next;

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data_q <= '0;
            overrun    <= 1'b0;
            cts        <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            // The head register holds its last value whenever the FIFO drains empty.
            if (level_next != '0) begin
                if (push_accept && (rd_next[ADDR_W-1:0] == wr_ptr[ADDR_W-1:0])) begin
                    out_data_q <= shift_reg;
                end else begin
                    out_data_q <= mem[rd_next[ADDR_W-1:0]];
                end
            end
            if (push_req && !push_accept) begin
                overrun <= 1'b1;
            end else if (clear_errors) begin
                overrun <= 1'b0;
            end
            if (level_q >= LEVEL_W'(CTS_HIGH_WATER)) begin
                cts <= 1'b1;
            end else if (level_q <= LEVEL_W'(CTS_LOW_WATER)) begin
                cts <= 1'b0;
            end
        end
    end

    assign out_if.level              = level_q;
    assign out_if.out_data_available = (level_q != '0);
    assign out_if.out_data           = out_data_q;
endmodule

// File: tb/tb_serial_rx_fifo.sv
// Bench for serial_rx_fifo: a queue-based reference of the receive stream
// compared every cycle, plus directed literal checks for each scenario.
module tb_serial_rx_fifo;
    localparam int B             = 108;
    localparam int H             = B / 2;
    // Launch of a start bit (edge after rx falls) to the edge that registers the stop-bit result, 8N1.
    localparam int FRAME_TO_STOP = H + 2 + 9 * B;

    typedef enum int {EV_NONE, EV_PUSH, EV_FRAMING} ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_m = 1'b1;
    logic rx_p = 1'b1;
    logic clr_m = 1'b0;
    logic clr_p = 1'b0;
    logic cts_m, fe_m, pe_m, ovr_m;
    logic cts_p, fe_p, pe_p, ovr_p;

    serial_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_m ();
    serial_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_p ();

    serial_rx_fifo dut_m (
        .clk(clk), .rst_n(rst_n), .rx(rx_m), .cts(cts_m),
        .clear_errors(clr_m), .framing_error(fe_m), .parity_error(pe_m),
        .overrun(ovr_m), .out_if(if_m)
    );

    serial_rx_fifo #(.PARITY(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .cts(cts_p),
        .clear_errors(clr_p), .framing_error(fe_p), .parity_error(pe_p),
        .overrun(ovr_p), .out_if(if_p)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model of the main receiver's output stream.
    int         cyc = 0;
    ev_t        ev_kind = EV_NONE;
    int         ev_edge = -1;
    logic [7:0] ev_data = 8'h00;
    logic [7:0] m_q[$];
    logic [7:0] m_out = 8'h00;
    logic       m_cts = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ovr = 1'b0;
    bit         run_cmp = 1'b0;

    always @(posedge clk) begin
        int pre_lvl;
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_out = 8'h00;
            m_cts = 1'b0;
            m_fe  = 1'b0;
            m_pe  = 1'b0;
            m_ovr = 1'b0;
        end else begin
            pre_lvl = m_q.size();
            m_fe = 1'b0;
            m_pe = 1'b0;
            if (pre_lvl > 0 && if_m.receiver_ready) void'(m_q.pop_front());
            if (clr_m) m_ovr = 1'b0;
            if (ev_edge == cyc) begin
                if (ev_kind == EV_PUSH) begin
                    if (m_q.size() < 16) m_q.push_back(ev_data);
                    else m_ovr = 1'b1;
                end else if (ev_kind == EV_FRAMING) begin
                    m_fe = 1'b1;
                end
            end
            if (pre_lvl >= 12) m_cts = 1'b1;
            else if (pre_lvl <= 4) m_cts = 1'b0;
            if (m_q.size() > 0) m_out = m_q[0];
        end
    end

    always @(negedge clk) begin
        logic [17:0] act, exp;
        if (rst_n && run_cmp) begin
            act = {if_m.out_data_available, if_m.level, if_m.out_data, cts_m, fe_m, pe_m, ovr_m};
            exp = {m_q.size() != 0, 5'(m_q.size()), m_out, m_cts, m_fe, m_pe, m_ovr};
            check("cycle_outputs", 32'(act), 32'(exp));
        end
    end

    int   fe_cnt = 0;
    int   pe_cnt = 0;
    int   rise_level = -1;
    int   fall_level = -1;
    logic cts_q = 1'b0;

    always @(negedge clk) begin
        if (fe_m) fe_cnt++;
        if (pe_p) pe_cnt++;
        if (rst_n) begin
            if (cts_m && !cts_q && rise_level < 0) rise_level = int'(if_m.level);
            if (!cts_m && cts_q && fall_level < 0) fall_level = int'(if_m.level);
            cts_q = cts_m;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic drive_line(input bit to_par, input logic v, input int cycles);
        if (to_par) rx_p = v;
        else rx_m = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_at_stop, output logic [7:0] popped);
        popped  = 8'h00;
        ev_kind = EV_PUSH;
        ev_data = b;
        ev_edge = cyc + 1 + FRAME_TO_STOP;
        drive_line(1'b0, 1'b0, B);
        for (int i = 0; i < 8; i++) drive_line(1'b0, b[i], B);
        rx_m = 1'b1;
        repeat (H + 2) @(negedge clk);
        if (pop_at_stop) begin
            popped = if_m.out_data;
            if_m.receiver_ready = 1'b1;
        end
        @(negedge clk);
        if (pop_at_stop) if_m.receiver_ready = 1'b0;
        repeat (B - H - 3) @(negedge clk);
    endtask

    task automatic send_par(input logic [7:0] b, input logic pbit);
        drive_line(1'b1, 1'b0, B);
        for (int i = 0; i < 8; i++) drive_line(1'b1, b[i], B);
        drive_line(1'b1, pbit, B);
        drive_line(1'b1, 1'b1, B);
    endtask

    task automatic pop_one(output logic [7:0] v);
        v = if_m.out_data;
        if_m.receiver_ready = 1'b1;
        @(negedge clk);
        if_m.receiver_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"}, 32'(if_m.level), 32'd0);
        check({tag, "_avail"}, 32'(if_m.out_data_available), 32'd0);
        check({tag, "_data"}, 32'(if_m.out_data), 32'd0);
        check({tag, "_cts"}, 32'(cts_m), 32'd0);
        check({tag, "_framing"}, 32'(fe_m), 32'd0);
        check({tag, "_parity"}, 32'(pe_m), 32'd0);
        check({tag, "_overrun"}, 32'(ovr_m), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] exp_b;
        if_m.receiver_ready = 1'b0;
        if_p.receiver_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n   = 1'b1;
        run_cmp = 1'b1;
        repeat (20) @(negedge clk);

        // Single byte then pop.
        send_byte(8'h41, 1'b0, v);
        check("single_data", 32'(if_m.out_data), 32'h41);
        check("single_avail", 32'(if_m.out_data_available), 32'd1);
        check("single_level", 32'(if_m.level), 32'd1);
        pop_one(v);
        check("single_pop_level", 32'(if_m.level), 32'd0);
        check("single_hold_data", 32'(if_m.out_data), 32'h41);

        // Even parity: 0x41 has two ones, so a parity bit of 1 is wrong.
        send_par(8'h41, 1'b1);
        check("parity_bad_pulses", 32'(pe_cnt), 32'd1);
        check("parity_bad_level", 32'(if_p.level), 32'd0);
        send_par(8'h41, 1'b0);
        check("parity_ok_pulses", 32'(pe_cnt), 32'd1);
        check("parity_ok_level", 32'(if_p.level), 32'd1);
        check("parity_ok_data", 32'(if_p.out_data), 32'h41);

        // Line held low for 20 bit times: one framing error, then a clean byte.
        ev_kind = EV_FRAMING;
        ev_edge = cyc + 1 + FRAME_TO_STOP;
        drive_line(1'b0, 1'b0, 20 * B);
        drive_line(1'b0, 1'b1, 2 * B);
        check("break_framing_pulses", 32'(fe_cnt), 32'd1);
        check("break_level", 32'(if_m.level), 32'd0);
        send_byte(8'h55, 1'b0, v);
        check("after_break_data", 32'(if_m.out_data), 32'h55);
        check("after_break_level", 32'(if_m.level), 32'd1);

        // 30-clock glitch is rejected at the start-bit sample.
        drive_line(1'b0, 1'b0, 30);
        drive_line(1'b0, 1'b1, 3 * B);
        check("glitch_level", 32'(if_m.level), 32'd1);
        check("glitch_data", 32'(if_m.out_data), 32'h55);

        // Reset asserted in the middle of data bit 3 of an all-zero frame.
        drive_line(1'b0, 1'b0, 4 * B + H);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("midframe_reset");
        rst_n = 1'b1;
        drive_line(1'b0, 1'b0, H);
        drive_line(1'b0, 1'b1, 3 * B);
        check("post_reset_level", 32'(if_m.level), 32'd0);
        check("post_reset_data", 32'(if_m.out_data), 32'd0);
        send_byte(8'hA5, 1'b0, v);
        check("a5_data", 32'(if_m.out_data), 32'hA5);
        check("a5_level", 32'(if_m.level), 32'd1);
        pop_one(v);
        check("a5_pop_level", 32'(if_m.level), 32'd0);

        // Fill past capacity with the consumer stalled.
        for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b0, v);
        check("fill_cts_rise_level", 32'(rise_level), 32'd12);
        check("fill_level", 32'(if_m.level), 32'd16);
        check("fill_overrun", 32'(ovr_m), 32'd1);
        check("fill_cts", 32'(cts_m), 32'd1);
        check("fill_head", 32'(if_m.out_data), 32'h00);
        clr_m = 1'b1;
        @(negedge clk);
        clr_m = 1'b0;
        check("clear_overrun", 32'(ovr_m), 32'd0);

        // Push into a full FIFO in the same cycle as a pop.
        send_byte(8'h20, 1'b1, v);
        check("full_pop_value", 32'(v), 32'h00);
        check("full_pushpop_level", 32'(if_m.level), 32'd16);
        check("full_pushpop_overrun", 32'(ovr_m), 32'd0);

        for (int i = 0; i < 16; i++) begin
            pop_one(v);
            exp_b = (i < 15) ? 8'(i + 1) : 8'h20;
            check("drain_order", 32'(v), 32'(exp_b));
        end
        check("drain_cts_fall_level", 32'(fall_level), 32'd4);
        check("drain_level", 32'(if_m.level), 32'd0);
        check("drain_cts", 32'(cts_m), 32'd0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
